// File: rtl/pair_triple_bist.sv
// Self-test sequencer for the three-input majority detector: walks all eight
// input patterns, compares the detector response and records the failures.
module pair_triple_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       dut_in0,
    output logic       dut_in1,
    output logic       dut_in2,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [7:0] fail_mask,
    output logic [2:0] first_fail
);

    localparam int unsigned SW = 4;
    localparam int unsigned PW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   pat;
    logic [SW-1:0]   settle;

    logic expected_c;
    logic mismatch_c;
    logic last_settle_c;

    // Majority of the pattern currently driven; dut_in0 is the MSB.
    assign expected_c    = (pat[2] & pat[1]) | (pat[2] & pat[0]) | (pat[1] & pat[0]);
    assign mismatch_c    = (dut_out != expected_c);
    assign last_settle_c = (settle == SW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state                       <= IDLE;
            pat                         <= '0;
            settle                      <= '0;
            busy                        <= 1'b0;
            done                        <= 1'b0;
            pass                        <= 1'b0;
            fail_count                  <= '0;
            fail_mask                   <= '0;
            first_fail                  <= '0;
            {dut_in0, dut_in1, dut_in2} <= 3'b000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state                       <= RUN;
                        pat                         <= '0;
                        settle                      <= '0;
                        busy                        <= 1'b1;
                        done                        <= 1'b0;
                        pass                        <= 1'b0;
                        fail_count                  <= '0;
                        fail_mask                   <= '0;
                        first_fail                  <= '0;
                        {dut_in0, dut_in1, dut_in2} <= 3'b000;
                    end
                end
                RUN: begin
                    if (last_settle_c) begin
                        settle <= '0;
                        if (mismatch_c) begin
                            fail_mask[pat] <= 1'b1;
                            fail_count     <= fail_count + 4'd1;
                            if (fail_count == 4'd0) begin
                                first_fail <= pat;
                            end
                        end
                        // Last pattern compared: publish the verdict and release the detector.
                        if (pat == 3'd7) begin
                            state                       <= DONE;
                            busy                        <= 1'b0;
                            done                        <= 1'b1;
                            pass                        <= (fail_count == 4'd0) && !mismatch_c;
                            {dut_in0, dut_in1, dut_in2} <= 3'b000;
                        end else begin
                            pat                         <= pat + 3'd1;
                            {dut_in0, dut_in1, dut_in2} <= pat + 3'd1;
                        end
                    end else begin
                        settle <= settle + SW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_triple_bist.sv
// Scoreboard bench for pair_triple_bist: a behavioural detector (good, stuck-at-0
// or OR gate) answers the engine; instance b runs with SETTLE_CYCLES=3.
module tb_pair_triple_bist;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    int unsigned mode;
    bit sel;

    logic       a_in0, a_in1, a_in2, a_out, a_busy, a_done, a_pass;
    logic [3:0] a_fc;
    logic [7:0] a_fm;
    logic [2:0] a_ff;
    logic       b_in0, b_in1, b_in2, b_out, b_busy, b_done, b_pass;
    logic [3:0] b_fc;
    logic [7:0] b_fm;
    logic [2:0] b_ff;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] p);
        return (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
    endfunction

    function automatic logic det(input int unsigned m, input logic [2:0] p);
        case (m)
            1:       return 1'b0;
            2:       return |p;
            default: return maj(p);
        endcase
    endfunction

    assign a_out = det(mode, {a_in0, a_in1, a_in2});
    assign b_out = maj({b_in0, b_in1, b_in2});

    pair_triple_bist #(.SETTLE_CYCLES(1)) u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .dut_in0(a_in0), .dut_in1(a_in1), .dut_in2(a_in2), .dut_out(a_out),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .fail_count(a_fc), .fail_mask(a_fm), .first_fail(a_ff)
    );

    pair_triple_bist #(.SETTLE_CYCLES(3)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .dut_in0(b_in0), .dut_in1(b_in1), .dut_in2(b_in2), .dut_out(b_out),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .fail_count(b_fc), .fail_mask(b_fm), .first_fail(b_ff)
    );

    logic [2:0] c_in;
    logic       c_busy, c_done, c_pass;
    logic [3:0] c_fc;
    logic [7:0] c_fm;
    logic [2:0] c_ff;

    assign c_in   = sel ? {b_in0, b_in1, b_in2} : {a_in0, a_in1, a_in2};
    assign c_busy = sel ? b_busy : a_busy;
    assign c_done = sel ? b_done : a_done;
    assign c_pass = sel ? b_pass : a_pass;
    assign c_fc   = sel ? b_fc : a_fc;
    assign c_fm   = sel ? b_fm : a_fm;
    assign c_ff   = sel ? b_ff : a_ff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(c_busy), 32'(0));
        check({tag, "_done"}, 32'(c_done), 32'(0));
        check({tag, "_pass"}, 32'(c_pass), 32'(0));
        check({tag, "_fc"},   32'(c_fc),   32'(0));
        check({tag, "_fm"},   32'(c_fm),   32'(0));
        check({tag, "_ff"},   32'(c_ff),   32'(0));
        check({tag, "_in"},   32'(c_in),   32'(0));
    endtask

    // One full run; expected patterns are queued at start, popped each busy cycle.
    task automatic run(input bit s, input int unsigned m, input int unsigned S, input bit hold);
        logic [2:0]  exp_q[$];
        logic [7:0]  emask;
        logic [3:0]  ecnt;
        logic [2:0]  efirst;
        logic [7:0]  sofar;
        int unsigned compared;
        int          n;
        emask = '0; ecnt = '0; efirst = '0;
        mode = m;
        sel  = s;
        for (int p = 0; p < 8; p++) begin
            if (det(m, 3'(p)) != maj(3'(p))) begin
                if (ecnt == 4'd0) efirst = 3'(p);
                emask[p] = 1'b1;
                ecnt     = ecnt + 4'd1;
            end
        end
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < int'(S); k++) exp_q.push_back(3'(p));
        @(posedge clk);
        #1;
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("restart_done", 32'(c_done), 32'(0));
                check("restart_fc",   32'(c_fc),   32'(0));
            end
            if (c_done || n > int'(8 * S) + 2) break;
            check("busy", 32'(c_busy), 32'(1));
            if (exp_q.size() != 0)
                check("pattern", 32'(c_in), 32'(exp_q.pop_front()));
            else
                check("overrun", 32'(n), 32'(8 * S));
            compared = (n - 1) / S;
            sofar    = emask & 8'((9'd1 << compared) - 9'd1);
            check("mask_run", 32'(c_fm), 32'(sofar));
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check("done",        32'(c_done),       32'(1));
        check("run_len",     32'(n - 1),        32'(8 * S));
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        check("busy_end",    32'(c_busy),       32'(0));
        check("pass",        32'(c_pass),       32'(ecnt == 4'd0));
        check("fail_count",  32'(c_fc),         32'(ecnt));
        check("fail_mask",   32'(c_fm),         32'(emask));
        check("first_fail",  32'(c_ff),         32'(efirst));
        check("in_idle",     32'(c_in),         32'(0));
        // Results must hold after the run with start low.
        @(negedge clk);
        check("hold_done",   32'(c_done),       32'(1));
        check("hold_mask",   32'(c_fm),         32'(emask));
    endtask

    initial begin
        int  waited;
        mode    = 0;
        sel     = 1'b0;
        reset   = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0; check_reset_vals("rst_a");
        sel = 1'b1; check_reset_vals("rst_b");
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;

        run(1'b0, 0, 1, 1'b0);   // correct detector
        run(1'b0, 1, 1, 1'b0);   // stuck-at-0, started from DONE
        run(1'b0, 2, 1, 1'b0);   // OR gate, started from DONE
        run(1'b0, 0, 1, 1'b1);   // start held high through the run

        // Reset while pattern 4 is on the detector inputs.
        sel  = 1'b0;
        mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (c_in != 3'd4 && waited < 12);
        check("reach_pat4", 32'(c_in), 32'(4));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midrst");
        @(negedge clk);
        check_reset_vals("midrst_idle");

        run(1'b1, 0, 3, 1'b0);   // SETTLE_CYCLES=3

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pair_triple_bist.md
# pair_triple_bist

Built-in self-test engine for the three-input pair/triple (majority) detector. After a `start` pulse it drives all eight input combinations into the detector in ascending order. It compares the detector's `out` against the expected majority value on every pattern and reports pass/fail, a per-pattern fail mask, a fail count and the first failing pattern. It sits beside the detector instance and drives its `in0`/`in1`/`in2` ports in place of the functional inputs while the detector is under test.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: cycles each pattern is held before `dut_out` is compared; legal range 1..15.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: begin a test run; sampled only in IDLE or DONE.
- `dut_in0` output 1: drives detector `in0`.
- `dut_in1` output 1: drives detector `in1`.
- `dut_in2` output 1: drives detector `in2`.
- `dut_out` input 1: detector response.
- `busy` output 1: run in progress.
- `done` output 1: run complete; results valid.
- `pass` output 1: `done` and no mismatches.
- `fail_count` output 4: number of mismatching patterns, 0..8.
- `fail_mask` output 8: bit p = 1 if pattern p mismatched.
- `first_fail` output 3: lowest-numbered failing pattern; 0 when `fail_count` is 0.

## Operation

- Pattern p (0..7) is driven as `{dut_in0,dut_in1,dut_in2}` = p[2:0], so `dut_in0` is the MSB.
- Expected response is 1 when at least two of the three bits are 1. Patterns 3, 5, 6 and 7 expect 1; all others expect 0.
- **IDLE state.**
  - `busy`=0, `done`=0, `dut_in*`=0.
  - `start`=1 moves to RUN: clears the pattern counter, settle counter, `fail_count`, `fail_mask` and `first_fail`.
- **RUN state.**
  - `busy`=1 and the current pattern is driven.
  - The settle counter counts 0..`SETTLE_CYCLES`-1.
  - At the edge ending settle count `SETTLE_CYCLES`-1, `dut_out` is compared with the expected value.
  - On a mismatch: set `fail_mask[p]` and increment `fail_count`. If this is the first mismatch, load `first_fail` with p.
  - After that edge the pattern counter advances.
  - After pattern 7 is compared, go to DONE.
- **DONE state.**
  - `busy`=0, `done`=1, `pass` = (`fail_count`==0), `dut_in*`=0.
  - Results hold until the next `start` or `reset`.
  - `start`=1 behaves as it does in IDLE: clears results, goes to RUN, deasserts `done`.
- **Boundary conditions.**
  - `start` during RUN is ignored.
  - `fail_count` cannot exceed 8, so no saturation logic is required.
  - `first_fail` is loaded only while `fail_count`==0.
  - `dut_out` is ignored outside RUN.
  - Reset mid-run aborts the run. All outputs take their reset values and no partial results are retained.
- **Reset values.**
  - State IDLE.
  - `busy`, `done`, `pass` = 0.
  - `fail_count`=0, `fail_mask`=0, `first_fail`=0.
  - `dut_in0`, `dut_in1`, `dut_in2` = 0.

## Timing

- `start` is sampled at edge E0. From E0, `busy`=1 and pattern 0 is driven.
- Pattern p is driven during the interval E0+S·p to E0+S·(p+1), where S = `SETTLE_CYCLES`.
- Pattern p is compared at edge E0+S·(p+1).
- `fail_count`, `fail_mask` and `first_fail` reflect pattern p's comparison immediately after its compare edge.
- At edge E0+8S: `done`=1, `busy`=0, `pass` valid.
- Total run time is 8S cycles; with the default S=1 that is 8 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from `dut_out` or `start` to any output.
- The detector is combinational; S=1 gives a full cycle of settle time.

## Test plan

- **Reset.** Assert `reset` for 2 cycles with `start`=1 → `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `fail_mask`=0, `first_fail`=0, `dut_in*`=000.
- **Correct detector, S=1.** Pulse `start` → `dut_in*` steps through 000, 001, …, 111 on 8 consecutive cycles. `done`=1 exactly 8 cycles after the `start` edge, with `pass`=1, `fail_count`=0, `fail_mask`=8'h00.
- **Stuck-at-0 detector.** Pulse `start` → `fail_mask`=8'b1110_1000, `fail_count`=4, `first_fail`=3'b011, `pass`=0.
- **OR-gate detector** (out = in0|in1|in2). Pulse `start` → `fail_mask`=8'b0001_0110, `fail_count`=3, `first_fail`=3'b001, `pass`=0.
- **Control corner cases.**
  - `start` held high throughout a run → no restart; `done` still asserts at cycle 8.
  - `start` in DONE → results clear, a new run begins, `done`=0 on the next cycle.
  - `reset` while pattern 4 is driven → IDLE with all outputs at reset values.
- **SETTLE_CYCLES=3, correct detector.** Pulse `start` → each pattern held 3 cycles, `done` 24 cycles after `start`, `pass`=1.
